eig_sequencer: RTL and testbench

Controller that sequences the parameter-load → eigen-computation → output-serialisation pipeline of the watchdog design. Sits between `param_loader`, `eig_core` and `output_loader`. Issues start pulses, tracks busy handshakes and captures core results into holding registers for the output loader. Buffers one pending load request, flags overruns and optionally aborts hung stages on timeout.

---
 rtl/watchdog_pkg.sv | 15 +
 rtl/seq_timer.sv | 28 ++
 rtl/eig_sequencer.sv | 161 ++++++++++++++++
 tb/tb_eig_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/watchdog_pkg.sv
// Shared types and constants for the watchdog eigen pipeline.
package watchdog_pkg;

  localparam int unsigned REGIME_W   = 3;
  localparam int unsigned EIG_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_C_ACK,
    ST_C_RUN,
    ST_O_ACK,
    ST_O_RUN
  } eig_seq_state_t;

endpackage

// File: rtl/seq_timer.sv
// Per-state wait counter: clear on state entry, count while waiting, flag the last allowed cycle.
module seq_timer #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expire = (cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/eig_sequencer.sv
// Sequences param load -> eig_core -> output_loader with a one-deep request buffer.
// Optional stage timeout is compiled in with `define EIG_SEQ_TIMEOUT_EN.
module eig_sequencer
  import watchdog_pkg::*;
#(
  parameter int unsigned DATA_W      = EIG_DATA_W,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                pl_valid,
  output logic                pl_busy,
  output logic                core_start,
  input  logic                core_busy,
  input  logic [DATA_W-1:0]   core_kappa,
  input  logic [DATA_W-1:0]   core_inv_kappa,
  input  logic [REGIME_W-1:0] core_regime,
  output logic                ol_start,
  input  logic                ol_busy,
  output logic [DATA_W-1:0]   ol_word_a,
  output logic [DATA_W-1:0]   ol_word_b,
  output logic [REGIME_W-1:0] ol_mode,
  input  logic                status_clr,
  output logic                overrun,
  output logic                timeout
);

  eig_seq_state_t state, state_nxt;

  logic pending, pending_nxt;
  logic core_go, capture, overrun_set, to_flag, expire;
  logic core_start_q, ol_start_q, pl_busy_q, overrun_q;
  logic [DATA_W-1:0]   word_a_q, word_b_q;
  logic [REGIME_W-1:0] mode_q;

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    core_go     = 1'b0;
    capture     = 1'b0;
    overrun_set = 1'b0;
    to_flag     = 1'b0;
    if (ena) begin
      unique case (state)
        ST_IDLE: begin
          if (pl_valid || pending) begin
            state_nxt   = ST_C_ACK;
            core_go     = 1'b1;
            // a request arriving while the buffered one is consumed takes its place
            pending_nxt = pending & pl_valid;
          end
        end
        ST_C_ACK: begin
          if (core_busy) begin
            state_nxt = ST_C_RUN;
          end else if (expire) begin
            state_nxt = ST_IDLE;
            to_flag   = 1'b1;
          end
        end
        ST_C_RUN: begin
          if (!core_busy) begin
            state_nxt = ST_O_ACK;
            capture   = 1'b1;
          end else if (expire) begin
            state_nxt = ST_IDLE;
            to_flag   = 1'b1;
          end
        end
        ST_O_ACK: begin
          if (ol_busy) begin
            state_nxt = ST_O_RUN;
          end else if (expire) begin
            state_nxt = ST_IDLE;
            to_flag   = 1'b1;
          end
        end
        ST_O_RUN: begin
          if (!ol_busy) begin
            state_nxt = ST_IDLE;
          end else if (expire) begin
            state_nxt = ST_IDLE;
            to_flag   = 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
      if (state != ST_IDLE && pl_valid) begin
        if (pending) overrun_set = 1'b1;
        else         pending_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      pending      <= 1'b0;
      core_start_q <= 1'b0;
      ol_start_q   <= 1'b0;
      pl_busy_q    <= 1'b0;
      overrun_q    <= 1'b0;
      word_a_q     <= '0;
      word_b_q     <= '0;
      mode_q       <= '0;
    end else if (ena) begin
      state        <= state_nxt;
      pending      <= pending_nxt;
      core_start_q <= core_go;
      ol_start_q   <= capture;
      pl_busy_q    <= (state_nxt != ST_IDLE);
      overrun_q    <= overrun_set | (overrun_q & ~status_clr);
      if (capture) begin
        word_a_q <= core_kappa;
        word_b_q <= core_inv_kappa;
        mode_q   <= core_regime;
      end
    end
  end

  // pulse registers hold while disabled, so a due start is emitted once ena returns
  assign core_start = core_start_q & ena;
  assign ol_start   = ol_start_q & ena;
  assign pl_busy    = pl_busy_q;
  assign overrun    = overrun_q;
  assign ol_word_a  = word_a_q;
  assign ol_word_b  = word_b_q;
  assign ol_mode    = mode_q;

`ifdef EIG_SEQ_TIMEOUT_EN
  logic timeout_q;

  seq_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ena && (state_nxt != state)),
    .en    (ena && (state != ST_IDLE)),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else if (ena) begin
      timeout_q <= to_flag | (timeout_q & ~status_clr);
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout_cfg;

  assign expire             = 1'b0;
  assign timeout            = 1'b0;
  assign unused_timeout_cfg = ^{TIMEOUT_CYC, to_flag};
`endif

endmodule

// File: tb/tb_eig_sequencer.sv
// Directed bench for eig_sequencer: nominal, buffering/overrun, enable freeze, reset, timeout.
`timescale 1ns/1ps
module tb_eig_sequencer;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n, ena, pl_valid, core_busy, ol_busy, status_clr;
  logic [DW-1:0] core_kappa, core_inv_kappa;
  logic [2:0]    core_regime;
  logic          pl_busy, core_start, ol_start, overrun, timeout;
  logic [DW-1:0] ol_word_a, ol_word_b;
  logic [2:0]    ol_mode;

  int n_chk = 0;
  int n_err = 0;
  int n_cs  = 0;
  int n_os  = 0;
  int cs0, os0;

  always #5 clk = ~clk;

  eig_sequencer #(
    .DATA_W     (DW),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .pl_valid      (pl_valid),
    .pl_busy       (pl_busy),
    .core_start    (core_start),
    .core_busy     (core_busy),
    .core_kappa    (core_kappa),
    .core_inv_kappa(core_inv_kappa),
    .core_regime   (core_regime),
    .ol_start      (ol_start),
    .ol_busy       (ol_busy),
    .ol_word_a     (ol_word_a),
    .ol_word_b     (ol_word_b),
    .ol_mode       (ol_mode),
    .status_clr    (status_clr),
    .overrun       (overrun),
    .timeout       (timeout)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (core_start) n_cs++;
      if (ol_start)   n_os++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; pl_valid = 1'b0; core_busy = 1'b0; ol_busy = 1'b0;
    status_clr = 1'b0; core_kappa = '0; core_inv_kappa = '0; core_regime = '0;
    step(); step();
    check_eq("rst_pl_busy", pl_busy, 0);
    check_eq("rst_core_start", core_start, 0);
    check_eq("rst_ol_word_a", ol_word_a, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_timeout", timeout, 0);
    rst_n = 1'b1;
    step();

    // nominal transaction
    cs0 = n_cs; os0 = n_os;
    pl_valid = 1'b1; step(); pl_valid = 1'b0;
    check_eq("t1_core_start", core_start, 1);
    check_eq("t1_pl_busy", pl_busy, 1);
    core_kappa = 32'h0001_0000; core_inv_kappa = 32'h0000_FFFF; core_regime = 3'd2;
    core_busy = 1'b1;
    repeat (3) step();
    check_eq("t1_no_ol_start", ol_start, 0);
    core_busy = 1'b0; step();
    check_eq("t1_ol_start", ol_start, 1);
    check_eq("t1_word_a", ol_word_a, 32'h0001_0000);
    check_eq("t1_word_b", ol_word_b, 32'h0000_FFFF);
    check_eq("t1_mode", ol_mode, 2);
    core_kappa = 32'hDEAD_BEEF; core_regime = 3'd5;
    ol_busy = 1'b1;
    repeat (4) step();
    check_eq("t1_word_a_held", ol_word_a, 32'h0001_0000);
    check_eq("t1_mode_held", ol_mode, 2);
    check_eq("t1_busy_orun", pl_busy, 1);
    ol_busy = 1'b0; step();
    check_eq("t1_idle", pl_busy, 0);
    check_eq("t1_cs_count", n_cs - cs0, 1);
    check_eq("t1_os_count", n_os - os0, 1);

    // buffering and overrun
    step();
    pl_valid = 1'b1; step(); pl_valid = 1'b0;
    core_busy = 1'b1; step();
    pl_valid = 1'b1; step(); pl_valid = 1'b0;
    check_eq("t2_no_overrun", overrun, 0);
    core_busy = 1'b0; step();
    ol_busy = 1'b1; step();
    pl_valid = 1'b1; step(); pl_valid = 1'b0;
    check_eq("t2_overrun", overrun, 1);
    ol_busy = 1'b0; step();
    check_eq("t2_idle_gap", pl_busy, 0);
    check_eq("t2_no_early_start", core_start, 0);
    step();
    check_eq("t2_b2b_start", core_start, 1);
    status_clr = 1'b1; core_busy = 1'b1; step(); status_clr = 1'b0;
    check_eq("t2_overrun_clr", overrun, 0);
    core_busy = 1'b0; step();
    ol_busy = 1'b1; step();
    ol_busy = 1'b0; step();
    check_eq("t2_idle", pl_busy, 0);
    cs0 = n_cs;
    repeat (3) step();
    check_eq("t2_third_dropped", n_cs - cs0, 0);
    check_eq("t2_word_a", ol_word_a, 32'hDEAD_BEEF);

    // enable freeze with a start pulse due
    core_kappa = 32'h1234_5678; core_regime = 3'd1;
    pl_valid = 1'b1; step(); pl_valid = 1'b0; ena = 1'b0; #1;
    cs0 = n_cs;
    check_eq("t3_frz_start0", core_start, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("t3_frz_start", core_start, 0);
      check_eq("t3_frz_busy", pl_busy, 1);
      check_eq("t3_frz_word_a", ol_word_a, 32'hDEAD_BEEF);
    end
    step(); ena = 1'b1; #1;
    check_eq("t3_resume_start", core_start, 1);
    core_busy = 1'b1; step();
    check_eq("t3_single_pulse", core_start, 0);
    check_eq("t3_cs_count", n_cs - cs0, 1);
    core_busy = 1'b0; step();
    check_eq("t3_word_a", ol_word_a, 32'h1234_5678);
    ol_busy = 1'b1; step();
    ol_busy = 1'b0; step();
    check_eq("t3_idle", pl_busy, 0);

    // asynchronous reset during O_RUN
    pl_valid = 1'b1; step(); pl_valid = 1'b0;
    core_busy = 1'b1; step();
    core_busy = 1'b0; step();
    ol_busy = 1'b1; step();
    check_eq("t4_busy_pre", pl_busy, 1);
    #3 rst_n = 1'b0; #1;
    check_eq("t4_rst_busy", pl_busy, 0);
    check_eq("t4_rst_word_a", ol_word_a, 0);
    check_eq("t4_rst_word_b", ol_word_b, 0);
    check_eq("t4_rst_mode", ol_mode, 0);
    check_eq("t4_rst_ol_start", ol_start, 0);
    ol_busy = 1'b0;
    step(); rst_n = 1'b1;
    cs0 = n_cs;
    repeat (3) step();
    check_eq("t4_stay_idle", pl_busy, 0);
    check_eq("t4_no_start", n_cs - cs0, 0);
    pl_valid = 1'b1; step(); pl_valid = 1'b0;
    check_eq("t4_restart", core_start, 1);
    core_busy = 1'b1; step();
    core_busy = 1'b0; step();
    ol_busy = 1'b1; step();
    ol_busy = 1'b0; step();
    check_eq("t4_idle", pl_busy, 0);

    // core never acknowledges
    os0 = n_os;
    pl_valid = 1'b1; step(); pl_valid = 1'b0;
    repeat (15) step();
    check_eq("t5_still_wait", pl_busy, 1);
    check_eq("t5_no_to_yet", timeout, 0);
    step();
`ifdef EIG_SEQ_TIMEOUT_EN
    check_eq("t5_abort_idle", pl_busy, 0);
    check_eq("t5_timeout", timeout, 1);
    check_eq("t5_no_ol_start", n_os - os0, 0);
    status_clr = 1'b1; step(); status_clr = 1'b0;
    check_eq("t5_timeout_clr", timeout, 0);
`else
    check_eq("t5_stuck_busy", pl_busy, 1);
    check_eq("t5_timeout_off", timeout, 0);
    check_eq("t5_no_ol_start", n_os - os0, 0);
    core_busy = 1'b1; step();
    core_busy = 1'b0; step();
    ol_busy = 1'b1; step();
    ol_busy = 1'b0; step();
    check_eq("t5_recover_idle", pl_busy, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
